// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues in-order fetch requests under a credit limit, tags each
// returned word with its PC, and queues it for decode. A redirect flushes the buffer and discards old-path responses.
module fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_fault,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        decode_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [31:0]   fetch_pc_reg, resp_pc_reg;

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          fault_mem[DEPTH];
    logic [DEPTH-1:0] entry_wen;

    logic [CW:0]   occupancy;
    logic          grant, drop_hit, push, pop;

    // Outstanding fetches plus buffered entries may never exceed DEPTH, so a response always has a slot.
    assign occupancy = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign imem_req  = !rst && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_reg;

    assign grant    = imem_req && imem_gnt;
    assign drop_hit = imem_rvalid && (drop_reg != '0);
    assign push     = imem_rvalid && !drop_hit && !redirect;
    assign pop      = instr_valid && decode_ready && !redirect;

    assign instr_valid = (count_reg != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr_reg]  : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]    : '0;
    assign instr_fault = instr_valid ? fault_mem[rd_ptr_reg] : 1'b0;

    always_comb begin
        outstanding_next = outstanding_reg + CW'(grant) - CW'(imem_rvalid);
        drop_next        = drop_reg - CW'(drop_hit);
        count_next       = count_reg + CW'(push) - CW'(pop);
        if (redirect) begin
            // Every request still in flight after this edge belongs to the old path.
            drop_next  = outstanding_next;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
        end else begin
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            if (redirect) begin
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                fetch_pc_reg <= redirect_pc;
                resp_pc_reg  <= redirect_pc;
            end else begin
                if (pop)   rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                if (push)  wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                if (grant) fetch_pc_reg <= fetch_pc_reg + 32'd4;
                if (push)  resp_pc_reg  <= resp_pc_reg + 32'd4;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
            assign entry_wen[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage needs no reset: outputs are masked by instr_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_wen[i]) begin
                data_mem[i]  <= imem_rdata;
                pc_mem[i]    <= resp_pc_reg;
                fault_mem[i] <= imem_fault;
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: a memory model answers grants in order, and a monitor
// compares decode-side entries and fetch requests against a queue-based reference model.
module tb_fetch_buffer;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_fault = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        decode_ready = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_fault(imem_fault),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_fault(instr_fault),
        .decode_ready(decode_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; logic fault; } ent_t;

    req_t        inflight[$];   // granted, not yet answered (any path)
    ent_t        buffered[$];   // entries decode should see, in order
    logic [31:0] model_pc;
    int          epoch;
    int          checks;
    int          failures;
    int          pops;
    bit          mon_en;
    int          gnt_pct, rv_pct, rdy_pct, redir_pct;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic fault_of(input logic [31:0] addr);
        return addr[4:2] == 3'b010;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit   exp_req;
        req_t r;
        if (mon_en && !rst) begin
            exp_req = !redirect && ((inflight.size() + buffered.size()) < DEPTH);
            check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (exp_req) check("imem_addr", imem_addr, model_pc);
            check("instr_valid", {31'd0, instr_valid}, {31'd0, buffered.size() != 0});
            if (buffered.size() != 0) begin
                check("instr", instr, buffered[0].data);
                check("instr_pc", instr_pc, buffered[0].pc);
                check("instr_fault", {31'd0, instr_fault}, {31'd0, buffered[0].fault});
                if (decode_ready && !redirect) begin
                    $display("pop pc=%h instr=%h fault=%0d", buffered[0].pc, buffered[0].data, buffered[0].fault);
                    pops++;
                    void'(buffered.pop_front());
                end
            end
            if (imem_rvalid) begin
                r = inflight.pop_front();
                if (!redirect && r.epoch == epoch)
                    buffered.push_back('{word_of(r.addr), r.addr, fault_of(r.addr)});
            end
            if (exp_req && imem_gnt) begin
                inflight.push_back('{model_pc, epoch});
                model_pc = model_pc + 32'd4;
            end
            if (redirect) begin
                epoch++;
                buffered.delete();
                model_pc = redirect_pc;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_instr_fault", {31'd0, instr_fault}, 32'd0);
    endtask

    // Drive one cycle of stimulus just after the rising edge, using the current knobs.
    task automatic drive_cycle(input bit force_redirect, input logic [31:0] force_pc);
        int sel;
        @(posedge clk);
        #1;
        imem_gnt     = ($urandom_range(0, 99) < gnt_pct);
        decode_ready = ($urandom_range(0, 99) < rdy_pct);
        if (inflight.size() != 0 && $urandom_range(0, 99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(inflight[0].addr);
            imem_fault  = fault_of(inflight[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            imem_fault  = 1'b0;
        end
        redirect = force_redirect || ($urandom_range(0, 99) < redir_pct);
        if (force_redirect) redirect_pc = force_pc;
        else begin
            sel = $urandom_range(0, 3);
            redirect_pc = (sel == 0) ? 32'h0000_1000 :
                          (sel == 1) ? 32'hFFFF_FFF8 : {18'd0, 12'($urandom), 2'b00};
        end
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int rd);
        gnt_pct = g; rv_pct = rv; rdy_pct = rdy; redir_pct = rd;
    endtask

    task automatic model_reset();
        inflight.delete();
        buffered.delete();
        model_pc = RESET_PC;
        epoch++;
    endtask

    initial begin
        checks = 0; failures = 0; pops = 0; epoch = 0; mon_en = 0;
        model_pc = RESET_PC;
        rst = 1'b1;
        #12;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1;

        // Streaming: always granted, answered one cycle later, decode always ready.
        set_knobs(100, 100, 100, 0);
        repeat (20) drive_cycle(0, '0);

        // Stalled decode fills the buffer and throttles requests; then drain.
        set_knobs(100, 100, 0, 0);
        repeat (10) drive_cycle(0, '0);
        set_knobs(100, 100, 100, 0);
        repeat (10) drive_cycle(0, '0);

        // Build two outstanding requests, redirect to 0x1000 with nothing returned yet.
        set_knobs(0, 100, 100, 0);
        repeat (4) drive_cycle(0, '0);
        set_knobs(100, 0, 100, 0);
        repeat (2) drive_cycle(0, '0);
        set_knobs(0, 0, 100, 0);
        drive_cycle(1, 32'h0000_1000);
        set_knobs(100, 100, 100, 0);
        repeat (12) drive_cycle(0, '0);

        // Randomized traffic with occasional redirects.
        set_knobs(70, 60, 70, 5);
        repeat (700) drive_cycle(0, '0);

        // Mid-stream reset, preferably with two requests in flight.
        set_knobs(100, 0, 0, 0);
        for (int i = 0; i < 10 && inflight.size() < DEPTH; i++) drive_cycle(0, '0);
        @(posedge clk); #1;
        imem_gnt = 0; imem_rvalid = 0; redirect = 0; decode_ready = 0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        set_knobs(100, 100, 100, 0);
        repeat (10) drive_cycle(0, '0);
        set_knobs(60, 50, 60, 8);
        repeat (700) drive_cycle(0, '0);

        @(posedge clk); #1;
        imem_gnt = 0; imem_rvalid = 0; redirect = 0; decode_ready = 0;
        @(posedge clk); #1;
        mon_en = 0;
        if (pops < 50) begin
            failures++;
            $display("FAIL pop_count actual=%0d required>=50", pops);
        end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
